irrigation_matrix_scanner: RTL and testbench

//  Drives the kit's 5x7 LED matrix directly: time-multiplexes columns and animates the irrigation

---
 rtl/irrigation_matrix_pkg.sv | 18 +
 rtl/irrigation_frame_rom.sv | 50 +++++
 rtl/irrigation_matrix_scanner.sv | 111 +++++++++++
 tb/tb_irrigation_matrix_scanner.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_matrix_pkg.sv
// Shared definitions for the irrigation matrix display: mode encodings and
// the mirror-distance helper used to fold the symmetric pictogram.
package irrigation_matrix_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_SPRINKLER = 2'b01,
        MODE_DRIPPER   = 2'b10,
        MODE_FAULT     = 2'b11
    } mode_e;

    function automatic int mirror_dist(input int col, input int n_cols);
        int d;
        d = col - (n_cols - 1) / 2;
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/irrigation_frame_rom.sv
// Combinational picture table: (mode, frame, mirror distance) -> row bits of
// one column of the irrigation pictogram.
module irrigation_frame_rom
    import irrigation_matrix_pkg::*;
#(
    parameter int N_ROWS = 7,
    parameter int FW     = 2,
    parameter int HW     = 2
) (
    input  logic [1:0]        i_mode,
    input  logic [FW-1:0]     i_frame,
    input  logic [HW-1:0]     i_h,
    output logic [N_ROWS-1:0] o_row
);

    int w_spray_row;
    int w_drip_row;

    // Spray arc drops one row on odd frames; the drop falls one row per frame.
    assign w_spray_row = N_ROWS - 1 - int'(i_h) - int'(i_frame[0]);
    assign w_drip_row  = N_ROWS - 1 - (int'(i_frame) % (N_ROWS - 1));

    always_comb begin
        // NOTE: default assignment first so every path drives o_row and no latch is inferred.
        o_row = '0;
        case (i_mode)
            MODE_OFF: begin
                if (i_h == '0) o_row = '1;
            end
            MODE_SPRINKLER: begin
                o_row[0] = 1'b1;
                if (i_h == '0) o_row = '1;
                for (int r = 1; r < N_ROWS; r++) begin
                    if (i_h != '0 && r == w_spray_row) o_row[r] = 1'b1;
                end
            end
            MODE_DRIPPER: begin
                o_row[0] = 1'b1;
                if (i_h == '0) o_row = '1;
                for (int r = 1; r < N_ROWS; r++) begin
                    if (i_h == HW'(1) && r == w_drip_row) o_row[r] = 1'b1;
                end
            end
            default: begin
                o_row = i_frame[0] ? '0 : '1;
            end
        endcase
    end

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Column-multiplexed 5x7 LED driver that animates the irrigation pictogram;
// mode is taken only at scan boundaries so a picture never tears.
module irrigation_matrix_scanner
    import irrigation_matrix_pkg::*;
#(
    parameter int N_COLS      = 5,
    parameter int N_ROWS      = 7,
    parameter int SCAN_DIV    = 1000,
    parameter int FRAME_SCANS = 50,
    parameter int N_FRAMES    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [N_COLS-1:0] col_n,
    output logic [N_ROWS-1:0] row,
    output logic [1:0]        mode_active,
    output logic              frame_start
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int SW = (FRAME_SCANS > 1) ? $clog2(FRAME_SCANS) : 1;
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int HW = ((N_COLS - 1) / 2 + 1 > 1) ? $clog2((N_COLS - 1) / 2 + 1) : 1;

    logic [DW-1:0]     r_div;
    logic [CW-1:0]     r_col;
    logic [SW-1:0]     r_scan;
    logic [FW-1:0]     r_frame;
    logic [1:0]        r_mode_active;
    logic [N_COLS-1:0] r_col_n;
    logic [N_ROWS-1:0] r_row;
    logic              r_frame_start;

    logic              w_div_end;
    logic              w_col_end;
    logic              w_scan_end;
    logic [HW-1:0]     w_h;
    logic [N_COLS-1:0] w_col_sel_n;
    logic [N_ROWS-1:0] w_rom_row;

    assign w_div_end   = (r_div == DW'(SCAN_DIV - 1));
    assign w_col_end   = (r_col == CW'(N_COLS - 1));
    assign w_scan_end  = (r_scan == SW'(FRAME_SCANS - 1));
    assign w_h         = HW'(mirror_dist(int'(r_col), N_COLS));
    assign w_col_sel_n = ~(N_COLS'(1) << r_col);

    irrigation_frame_rom #(
        .N_ROWS (N_ROWS),
        .FW     (FW),
        .HW     (HW)
    ) u_rom (
        .i_mode  (r_mode_active),
        .i_frame (r_frame),
        .i_h     (w_h),
        .o_row   (w_rom_row)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_col         <= '0;
            r_scan        <= '0;
            r_frame       <= '0;
            r_mode_active <= MODE_OFF;
            r_col_n       <= '1;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            r_col_n       <= '1;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_col_n       <= w_col_sel_n;
            r_row         <= w_rom_row;
            r_frame_start <= 1'b0;
            if (!w_div_end) begin
                r_div <= r_div + DW'(1);
            end else begin
                r_div <= '0;
                if (!w_col_end) begin
                    r_col <= r_col + CW'(1);
                end else begin
                    r_col         <= '0;
                    r_mode_active <= mode;
                    // A mode change restarts the animation and outranks a scan wrap.
                    if (mode != r_mode_active) begin
                        r_scan        <= '0;
                        r_frame       <= '0;
                        r_frame_start <= 1'b1;
                    end else if (w_scan_end) begin
                        r_scan        <= '0;
                        r_frame       <= r_frame + FW'(1);
                        r_frame_start <= 1'b1;
                    end else begin
                        r_scan <= r_scan + SW'(1);
                    end
                end
            end
        end
    end

    assign col_n       = r_col_n;
    assign row         = r_row;
    assign mode_active = r_mode_active;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_irrigation_matrix_scanner.sv
// Bench for irrigation_matrix_scanner: scenario tasks plus randomized mode and
// enable traffic, compared each cycle against a tick-count reference model.
module tb_irrigation_matrix_scanner;

    localparam int NC = 5;
    localparam int NR = 7;
    localparam int SD = 4;
    localparam int FS = 2;
    localparam int NF = 4;
    localparam int TICKS_PER_SCAN = SD * NC;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [NC-1:0] col_n;
    logic [NR-1:0] row;
    logic [1:0]    mode_active;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    irrigation_matrix_scanner #(
        .N_COLS      (NC),
        .N_ROWS      (NR),
        .SCAN_DIV    (SD),
        .FRAME_SCANS (FS),
        .N_FRAMES    (NF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .col_n       (col_n),
        .row         (row),
        .mode_active (mode_active),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Picture rules evaluated pixel by pixel from column index and frame number.
    function automatic logic [NR-1:0] picture(input int md, input int fr, input int c);
        logic [NR-1:0] p;
        int h;
        bit on;
        p = '0;
        h = c - (NC - 1) / 2;
        if (h < 0) h = -h;
        for (int r = 0; r < NR; r++) begin
            case (md)
                0: on = (h == 0);
                1: on = (h == 0) || (r == 0) ||
                        (h >= 1 && r >= 1 && r == ((fr % 2 == 0) ? NR - 1 - h : NR - 2 - h));
                2: on = (h == 0) || (r == 0) || (h == 1 && r == NR - 1 - (fr % (NR - 1)));
                default: on = (fr % 2 == 0);
            endcase
            p[r] = on;
        end
        return p;
    endfunction

    // Reference model: position within a scan as one tick count, frame derived
    // from the number of whole scans completed since the last mode switch.
    int            m_tick;
    int            m_scans;
    logic [1:0]    m_mode;
    logic [NC-1:0] e_col_n;
    logic [NR-1:0] e_row;
    logic          e_fs;
    int            e_mode_disp;
    int            e_frame_disp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tick       <= 0;
            m_scans      <= 0;
            m_mode       <= 2'b00;
            e_col_n      <= '1;
            e_row        <= '0;
            e_fs         <= 1'b0;
            e_mode_disp  <= 0;
            e_frame_disp <= 0;
        end else if (!enable) begin
            e_col_n <= '1;
            e_row   <= '0;
            e_fs    <= 1'b0;
        end else begin
            e_col_n      <= ~(NC'(1) << (m_tick / SD));
            e_row        <= picture(int'(m_mode), (m_scans / FS) % NF, m_tick / SD);
            e_mode_disp  <= int'(m_mode);
            e_frame_disp <= (m_scans / FS) % NF;
            e_fs         <= 1'b0;
            if (m_tick == TICKS_PER_SCAN - 1) begin
                m_tick <= 0;
                m_mode <= mode;
                if (mode != m_mode) begin
                    m_scans <= 0;
                    e_fs    <= 1'b1;
                end else begin
                    m_scans <= m_scans + 1;
                    e_fs    <= ((m_scans + 1) % FS == 0);
                end
            end else begin
                m_tick <= m_tick + 1;
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b1;
        enable = 1'b1;
        mode   = 2'b00;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({col_n, row, mode_active, frame_start} !== {5'b11111, 7'b0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got=%b/%b/%b/%b want=11111/0000000/00/0",
                     col_n, row, mode_active, frame_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (col_n !== 5'b11110 || row !== 7'b0) begin
            bad++;
            $display("FAIL first_column got col_n=%b row=%b want 11110/0000000", col_n, row);
        end
    endtask

    task automatic test_off_scan();
        mode = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL off_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            total++;
            if ($countones(~col_n) != 1 || row !== ((col_n == 5'b11011) ? 7'h7f : 7'h00)) begin
                bad++;
                $display("FAIL off_picture got col_n=%b row=%b", col_n, row);
            end
        end
    endtask

    task automatic test_dripper();
        logic [NR-1:0] drip_tbl [NF];
        int last;
        drip_tbl = '{7'b1000001, 7'b0100001, 7'b0010001, 7'b0001001};
        last = -1;
        mode = 2'b10;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL drip_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            if (e_mode_disp == 2 && (col_n == 5'b11101 || col_n == 5'b10111)) begin
                total++;
                if (row !== drip_tbl[e_frame_disp]) begin
                    bad++;
                    $display("FAIL drip_col13 got=%b want=%b", row, drip_tbl[e_frame_disp]);
                end
            end
            if (e_mode_disp == 2 && (col_n == 5'b11110 || col_n == 5'b01111)) begin
                total++;
                if (row !== 7'b0000001) begin
                    bad++;
                    $display("FAIL drip_col04 got=%b want=0000001", row);
                end
            end
            if (frame_start) begin
                if (last >= 0) begin
                    total++;
                    if (i - last != 40) begin
                        bad++;
                        $display("FAIL drip_frame_period got=%0d want=40", i - last);
                    end
                end
                last = i;
            end
        end
    endtask

    task automatic test_mode_switch();
        int pulses;
        mode = 2'b01;
        repeat (45) @(negedge clk);
        for (int i = 0; i < 30 && col_n !== 5'b11011; i++) @(negedge clk);
        total++;
        if (col_n !== 5'b11011) begin
            bad++;
            $display("FAIL switch_wait_col2 got=%b want=11011", col_n);
        end
        mode   = 2'b10;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL switch_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            if (frame_start) pulses++;
            total++;
            if (mode_active !== ((pulses > 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL switch_mode_active got=%b after %0d pulses", mode_active, pulses);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL switch_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_fault();
        mode = 2'b11;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL fault_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            if (e_mode_disp == 3) begin
                total++;
                if (row !== ((e_frame_disp % 2 == 0) ? 7'h7f : 7'h00)) begin
                    bad++;
                    $display("FAIL fault_blink got=%b frame=%0d", row, e_frame_disp);
                end
            end
        end
    endtask

    task automatic test_disable();
        int cnt;
        for (int i = 0; i < 30 && col_n === 5'b10111; i++) @(negedge clk);
        for (int i = 0; i < 30 && col_n !== 5'b10111; i++) @(negedge clk);
        total++;
        if (col_n !== 5'b10111) begin
            bad++;
            $display("FAIL disable_wait_col3 got=%b want=10111", col_n);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, frame_start} !== {5'b11111, 7'b0, 1'b0}) begin
                bad++;
                $display("FAIL disable_blank got=%b/%b/%b want=11111/0000000/0",
                         col_n, row, frame_start);
            end
        end
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL resume_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            if (col_n == 5'b10111 && cnt == i) cnt++;
        end
        total++;
        if (cnt != 3) begin
            bad++;
            $display("FAIL resume_col3_cycles got=%0d want=3", cnt);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b10;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({col_n, row, mode_active, frame_start} !== {5'b11111, 7'b0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL midreset_blank got=%b/%b/%b/%b want=11111/0000000/00/0",
                     col_n, row, mode_active, frame_start);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (col_n !== 5'b11110 || mode_active !== 2'b00) begin
            bad++;
            $display("FAIL midreset_restart got col_n=%b mode_active=%b want 11110/00",
                     col_n, mode_active);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL midreset_model got=%b/%b/%b/%b want=%b/%b/%b/%b", col_n, row,
                         mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            total++;
            if ({col_n, row, mode_active, frame_start} !== {e_col_n, e_row, m_mode, e_fs}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", i, col_n,
                         row, mode_active, frame_start, e_col_n, e_row, m_mode, e_fs);
            end
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 99) < 92);
        end
        enable = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        mode   = 2'b00;
        test_reset();
        test_off_scan();
        test_dripper();
        test_mode_switch();
        test_fault();
        test_disable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
